burst_ram_arbiter: RTL

Two-port arbiter that shares a single BurstRAM between two burst requesters, such as an instruction cache and a data cache. It sits between the requesters' `br_`-style ports and the BurstRAM. It grants the RAM to one requester at a time using round-robin order and holds the grant for one complete burst. It also routes that burst's write beats to the RAM and its read beats back to the owner.

---
 rtl/burst_ram_arbiter.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/burst_ram_arbiter.sv
// Purpose: round-robin arbiter that shares one BurstRAM between two burst requesters (A and B).
// Latency: grant one cycle after req is sampled in IDLE; cmd, write beats and read beats pass through with no added cycle.
// Backpressure: a requester waits in req until granted; arbitration stalls while br_busy is high or br_init_calib is low.
//
// Ports:
//   clk, sys_rst_n                          clock, async active-low reset
//   a_*/b_*   req/cmd/cmd_en/addr/wr_data/data_mask in, gnt/rd_data/rd_data_valid out
//   br_*      command/write path to the BurstRAM, read data/valid, busy and calibration status back
module burst_ram_arbiter #(
    parameter int ADDR_BITWIDTH = 10,
    parameter int BURST_COUNT   = 4
) (
    input  logic                     clk,
    input  logic                     sys_rst_n,

    input  logic                     a_req,
    output logic                     a_gnt,
    input  logic                     a_cmd,
    input  logic                     a_cmd_en,
    input  logic [ADDR_BITWIDTH-1:0] a_addr,
    input  logic [63:0]              a_wr_data,
    input  logic [7:0]               a_data_mask,
    output logic [63:0]              a_rd_data,
    output logic                     a_rd_data_valid,

    input  logic                     b_req,
    output logic                     b_gnt,
    input  logic                     b_cmd,
    input  logic                     b_cmd_en,
    input  logic [ADDR_BITWIDTH-1:0] b_addr,
    input  logic [63:0]              b_wr_data,
    input  logic [7:0]               b_data_mask,
    output logic [63:0]              b_rd_data,
    output logic                     b_rd_data_valid,

    output logic                     br_cmd,
    output logic                     br_cmd_en,
    output logic [ADDR_BITWIDTH-1:0] br_addr,
    output logic [63:0]              br_wr_data,
    output logic [7:0]               br_data_mask,
    input  logic [63:0]              br_rd_data,
    input  logic                     br_rd_data_valid,
    input  logic                     br_busy,
    input  logic                     br_init_calib
);

    localparam int              CW        = $clog2(BURST_COUNT) + 1;
    localparam logic [CW-1:0]   LAST_BEAT = CW'(BURST_COUNT - 1);
    localparam logic            OWN_A     = 1'b0;
    localparam logic            OWN_B     = 1'b1;

    typedef enum logic [1:0] {IDLE, GRANT, WRITE, READ} state_t;

    state_t          state, state_nxt;
    logic            owner, owner_nxt;
    logic            last_owner, last_owner_nxt;
    logic [CW-1:0]   beat_cnt, beat_cnt_nxt;
    logic            a_gnt_nxt, b_gnt_nxt;
    logic            winner;
    logic            release_bus;

    // Inputs of whichever port currently owns the RAM.
    logic                     own_req, own_cmd, own_cmd_en;
    logic [ADDR_BITWIDTH-1:0] own_addr;
    logic [63:0]              own_wr_data;
    logic [7:0]               own_data_mask;

    assign own_req       = (owner == OWN_B) ? b_req       : a_req;
    assign own_cmd       = (owner == OWN_B) ? b_cmd       : a_cmd;
    assign own_cmd_en    = (owner == OWN_B) ? b_cmd_en    : a_cmd_en;
    assign own_addr      = (owner == OWN_B) ? b_addr      : a_addr;
    assign own_wr_data   = (owner == OWN_B) ? b_wr_data   : a_wr_data;
    assign own_data_mask = (owner == OWN_B) ? b_data_mask : a_data_mask;

    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state      <= IDLE;
            owner      <= OWN_A;
            last_owner <= OWN_B;
            beat_cnt   <= '0;
            a_gnt      <= 1'b0;
            b_gnt      <= 1'b0;
        end else begin
            state      <= state_nxt;
            owner      <= owner_nxt;
            last_owner <= last_owner_nxt;
            beat_cnt   <= beat_cnt_nxt;
            a_gnt      <= a_gnt_nxt;
            b_gnt      <= b_gnt_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        owner_nxt      = owner;
        last_owner_nxt = last_owner;
        beat_cnt_nxt   = beat_cnt;
        a_gnt_nxt      = a_gnt;
        b_gnt_nxt      = b_gnt;
        winner         = OWN_A;
        release_bus    = 1'b0;

        case (state)
            IDLE: begin
                if (br_init_calib && !br_busy && (a_req || b_req)) begin
                    // On a tie the port that did not own the previous burst wins.
                    winner    = (a_req && b_req) ? ~last_owner : b_req;
                    owner_nxt = winner;
                    a_gnt_nxt = (winner == OWN_A);
                    b_gnt_nxt = (winner == OWN_B);
                    state_nxt = GRANT;
                end
            end
            GRANT: begin
                if (own_cmd_en) begin
                    if (own_cmd) begin
                        // Strobe cycle already carried beat 0.
                        beat_cnt_nxt = CW'(1);
                        if (BURST_COUNT == 1) release_bus = 1'b1;
                        else                  state_nxt   = WRITE;
                    end else begin
                        beat_cnt_nxt = '0;
                        state_nxt    = READ;
                    end
                end else if (!own_req) begin
                    release_bus = 1'b1;
                end
            end
            WRITE: begin
                beat_cnt_nxt = beat_cnt + CW'(1);
                if (beat_cnt == LAST_BEAT) release_bus = 1'b1;
            end
            READ: begin
                if (br_rd_data_valid) begin
                    beat_cnt_nxt = beat_cnt + CW'(1);
                    if (beat_cnt == LAST_BEAT) release_bus = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase

        if (release_bus) begin
            a_gnt_nxt      = 1'b0;
            b_gnt_nxt      = 1'b0;
            last_owner_nxt = owner;
            state_nxt      = IDLE;
        end
    end

    // RAM-side command/write path: live only while a burst is being issued.
    always_comb begin
        br_cmd       = 1'b0;
        br_cmd_en    = 1'b0;
        br_addr      = '0;
        br_wr_data   = '0;
        br_data_mask = '0;
        if (state == GRANT) begin
            br_cmd       = own_cmd;
            br_cmd_en    = own_cmd_en;
            br_addr      = own_addr;
            br_wr_data   = own_wr_data;
            br_data_mask = own_data_mask;
        end else if (state == WRITE) begin
            br_wr_data   = own_wr_data;
            br_data_mask = own_data_mask;
        end
    end

    // Read data is broadcast; only the owner of an active read sees valid.
    assign a_rd_data       = br_rd_data;
    assign b_rd_data       = br_rd_data;
    assign a_rd_data_valid = (state == READ) && (owner == OWN_A) && br_rd_data_valid;
    assign b_rd_data_valid = (state == READ) && (owner == OWN_B) && br_rd_data_valid;

endmodule
